// File: rtl/blinker_cfg_sequencer.sv
// blinker_cfg_sequencer: AXI4-Lite master that loads NUM_REGS configuration words into the
// blinker IP on one start pulse. The optional read-back/compare phase is built under BLINKER_CFG_READBACK_EN.
module blinker_cfg_sequencer #(
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic [32*NUM_REGS-1:0]  cfg_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [3:0]              err_index,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [31:0]             M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [31:0]             M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_FIN
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t          state, state_nxt;
  logic [3:0]      idx;
  logic            aw_done, w_done;
  logic            aw_fin, w_fin;
  logic            err_set;
  logic [1:0]      err_code_nxt;
  logic            idx_inc, idx_clr;
  logic            last_reg;
  logic            tmo_hit;
  logic            waiting;
  logic [31:0]     tmo_cnt;
  logic [31:0]     shadow [16];
  logic [32*16-1:0] cfg_pad;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign cfg_pad  = (32*16)'(cfg_data);
  assign last_reg = (idx == LAST_IDX);
  assign cur_addr = ADDR_WIDTH'(BASE_ADDR + 32'({idx, 2'b00}));

  assign waiting = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                   (state == S_RD_REQ) || (state == S_RD_RESP);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && waiting && (tmo_cnt == TIMEOUT_CYCLES - 1);

  // Write-phase channel status: a handshake this cycle counts as complete
  assign M_AXI_AWVALID = (state == S_WR_REQ) && !aw_done;
  assign M_AXI_WVALID  = (state == S_WR_REQ) && !w_done;
  assign aw_fin        = aw_done || (M_AXI_AWVALID && M_AXI_AWREADY);
  assign w_fin         = w_done  || (M_AXI_WVALID  && M_AXI_WREADY);

  assign M_AXI_AWADDR = M_AXI_AWVALID ? cur_addr : '0;
  assign M_AXI_WDATA  = M_AXI_WVALID ? shadow[idx] : '0;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;
  assign M_AXI_BREADY = (state == S_WR_RESP);

`ifdef BLINKER_CFG_READBACK_EN
  assign M_AXI_ARVALID = (state == S_RD_REQ);
  assign M_AXI_RREADY  = (state == S_RD_RESP);
  assign M_AXI_ARADDR  = M_AXI_ARVALID ? cur_addr : '0;
`else
  logic unused_rd;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
  assign M_AXI_ARADDR  = '0;
  assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

  assign busy = waiting;
  assign done = (state == S_FIN);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_code_nxt = 2'd0;
    idx_inc      = 1'b0;
    idx_clr      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WR_REQ;
          idx_clr   = 1'b1;
        end
      end
      S_WR_REQ: begin
        if (aw_fin && w_fin) begin
          state_nxt = S_WR_RESP;
        end else if (tmo_hit) begin
          state_nxt    = S_FIN;
          err_set      = 1'b1;
          err_code_nxt = 2'd3;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            state_nxt    = S_FIN;
            err_set      = 1'b1;
            err_code_nxt = 2'd1;
          end else if (last_reg) begin
`ifdef BLINKER_CFG_READBACK_EN
            state_nxt = S_RD_REQ;
            idx_clr   = 1'b1;
`else
            state_nxt = S_FIN;
`endif
          end else begin
            state_nxt = S_WR_REQ;
            idx_inc   = 1'b1;
          end
        end else if (tmo_hit) begin
          state_nxt    = S_FIN;
          err_set      = 1'b1;
          err_code_nxt = 2'd3;
        end
      end
`ifdef BLINKER_CFG_READBACK_EN
      S_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          state_nxt = S_RD_RESP;
        end else if (tmo_hit) begin
          state_nxt    = S_FIN;
          err_set      = 1'b1;
          err_code_nxt = 2'd3;
        end
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          if ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != shadow[idx])) begin
            state_nxt    = S_FIN;
            err_set      = 1'b1;
            err_code_nxt = 2'd2;
          end else if (last_reg) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_RD_REQ;
            idx_inc   = 1'b1;
          end
        end else if (tmo_hit) begin
          state_nxt    = S_FIN;
          err_set      = 1'b1;
          err_code_nxt = 2'd3;
        end
      end
`endif
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx       <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      tmo_cnt   <= '0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      err_index <= 4'd0;
    end else begin
      // Counter restarts on every state change, so each handshake gets its own budget
      if (!waiting || (state_nxt != state)) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + 32'd1;

      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 4'd1;

      aw_done <= (state == S_WR_REQ) && (state_nxt == S_WR_REQ) && aw_fin;
      w_done  <= (state == S_WR_REQ) && (state_nxt == S_WR_REQ) && w_fin;

      if ((state == S_IDLE) && start) begin
        error     <= 1'b0;
        err_code  <= 2'd0;
        err_index <= 4'd0;
      end else if (err_set) begin
        error     <= 1'b1;
        err_code  <= err_code_nxt;
        err_index <= idx;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < 16; i++) shadow[i] <= '0;
    end else if ((state == S_IDLE) && start) begin
      for (int unsigned i = 0; i < 16; i++) shadow[i] <= cfg_pad[32*i +: 32];
    end
  end

endmodule

// File: tb/tb_blinker_cfg_sequencer.sv
// Self-checking bench for blinker_cfg_sequencer: table-driven sequences against a reactive
// AXI4-Lite slave model, plus hand-written timeout, start-while-busy and mid-write reset cases.
module tb_blinker_cfg_sequencer;
  localparam int NREG = 4;
`ifdef BLINKER_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic start = 1'b0;
  logic [32*NREG-1:0] cfg_data = '0;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [3:0] err_index;
  logic [3:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  blinker_cfg_sequencer #(
    .NUM_REGS(NREG), .ADDR_WIDTH(4), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model knobs and logs
  int aw_dly = 0, w_dly = 0, b_err = -1, r_bad = -1;
  bit aw_never = 1'b0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_high, w_high, done_cnt, drop_viol;
  int aw_wait, w_wait;
  bit aw_got, w_got, ar_got, prev_aw, prev_aw_hs, prev_w, prev_w_hs;
  logic [3:0]  rd_addr;
  logic [3:0]  aw_log [16];
  logic [31:0] w_log [16];
  logic [31:0] mem [4];

  task automatic clear_logs();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_high = 0; w_high = 0; done_cnt = 0; drop_viol = 0;
  endtask

  initial forever begin
    @(negedge ACLK);
    if (!ARESETN) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0;
      prev_aw = 0; prev_w = 0; prev_aw_hs = 0; prev_w_hs = 0;
    end else begin
      if (done) done_cnt++;
      if (prev_aw && !prev_aw_hs && !awvalid) drop_viol++;
      if (prev_w && !prev_w_hs && !wvalid) drop_viol++;
      bvalid = aw_got && w_got;
      bresp  = (bvalid && b_cnt == b_err) ? 2'b10 : 2'b00;
      if (bvalid && bready) begin
        if (b_cnt < 16) mem[aw_log[b_cnt][3:2]] = w_log[b_cnt];
        b_cnt++; aw_got = 0; w_got = 0;
      end
      awready = awvalid && !aw_never && (aw_wait >= aw_dly);
      wready  = wvalid && (w_wait >= w_dly);
      if (awvalid) aw_high++;
      if (wvalid)  w_high++;
      if (awvalid && !awready) aw_wait++;
      if (wvalid && !wready)   w_wait++;
      prev_aw = awvalid; prev_aw_hs = awvalid && awready;
      prev_w  = wvalid;  prev_w_hs  = wvalid && wready;
      if (awvalid && awready) begin
        if (aw_cnt < 16) aw_log[aw_cnt] = awaddr;
        aw_cnt++; aw_got = 1; aw_wait = 0;
      end
      if (wvalid && wready) begin
        if (w_cnt < 16) w_log[w_cnt] = wdata;
        w_cnt++; w_got = 1; w_wait = 0;
      end
      rvalid = ar_got;
      rdata  = (r_cnt == r_bad) ? 32'hFF : mem[rd_addr[3:2]];
      rresp  = 2'b00;
      if (rvalid && rready) begin r_cnt++; ar_got = 0; end
      arready = arvalid;
      if (arvalid && arready) begin ar_cnt++; rd_addr = araddr; ar_got = 1; end
    end
  end

  task automatic run_seq(output bit got_done);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("err_clr", error, 0);
    got_done = 1'b0;
    for (int i = 0; i < 400 && !got_done; i++) begin
      if (done) got_done = 1'b1;
      else @(negedge ACLK);
    end
    chk("done_seen", got_done, 1);
  endtask

  typedef struct {
    logic [127:0] cfg;
    int aw_dly; int w_dly; int b_err; int r_bad;
    logic exp_err; logic [1:0] exp_code; logic [3:0] exp_idx;
    int exp_wr; int exp_rd;
  } vec_t;

  vec_t vecs [8];
  localparam logic [127:0] CFG_A = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] CFG_B = {32'h0000FFFF, 32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF};

  initial begin
    bit got;
    vecs[0] = '{CFG_A, 0, 0, -1, -1, 1'b0, 2'd0, 4'd0, 4, RB ? 4 : 0};
    vecs[1] = '{CFG_A, 0, 0,  2, -1, 1'b1, 2'd1, 4'd2, 3, 0};
    vecs[2] = RB ? '{CFG_A, 0, 0, -1, 1, 1'b1, 2'd2, 4'd1, 4, 2}
                 : '{CFG_A, 0, 0, -1, 1, 1'b0, 2'd0, 4'd0, 4, 0};
    vecs[3] = '{CFG_A, 5, 0, -1, -1, 1'b0, 2'd0, 4'd0, 4, RB ? 4 : 0};
    vecs[4] = '{CFG_A, 0, 5, -1, -1, 1'b0, 2'd0, 4'd0, 4, RB ? 4 : 0};
    vecs[5] = '{CFG_B, 2, 3, -1, -1, 1'b0, 2'd0, 4'd0, 4, RB ? 4 : 0};
    vecs[6] = '{CFG_B, 0, 0,  0, -1, 1'b1, 2'd1, 4'd0, 1, 0};
    vecs[7] = '{CFG_B, 1, 0,  3, -1, 1'b1, 2'd1, 4'd3, 4, 0};

    clear_logs();
    #1;
    chk("rst_status", {busy, done, error, err_code, err_index}, 0);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_addr_data", {awaddr, araddr, wdata}, 0);
    chk("rst_prot_strb", {awprot, arprot, wstrb}, 32'h0F);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);

    for (int v = 0; v < 8; v++) begin
      cfg_data = vecs[v].cfg;
      aw_dly = vecs[v].aw_dly; w_dly = vecs[v].w_dly;
      b_err = vecs[v].b_err;   r_bad = vecs[v].r_bad;
      clear_logs();
      run_seq(got);
      chk($sformatf("v%0d_busy_at_done", v), busy, 0);
      chk($sformatf("v%0d_error", v), error, vecs[v].exp_err);
      chk($sformatf("v%0d_err_code", v), err_code, vecs[v].exp_code);
      chk($sformatf("v%0d_err_index", v), err_index, vecs[v].exp_idx);
      chk($sformatf("v%0d_aw_cnt", v), aw_cnt, vecs[v].exp_wr);
      chk($sformatf("v%0d_w_cnt", v), w_cnt, vecs[v].exp_wr);
      chk($sformatf("v%0d_ar_cnt", v), ar_cnt, vecs[v].exp_rd);
      chk($sformatf("v%0d_r_cnt", v), r_cnt, vecs[v].exp_rd);
      chk($sformatf("v%0d_aw_high", v), aw_high, vecs[v].exp_wr * (vecs[v].aw_dly + 1));
      chk($sformatf("v%0d_w_high", v), w_high, vecs[v].exp_wr * (vecs[v].w_dly + 1));
      chk($sformatf("v%0d_drop", v), drop_viol, 0);
      for (int i = 0; i < vecs[v].exp_wr && i < aw_cnt && i < w_cnt; i++) begin
        chk($sformatf("v%0d_awaddr%0d", v, i), aw_log[i], 4 * i);
        chk($sformatf("v%0d_wdata%0d", v, i), w_log[i], vecs[v].cfg[32*i +: 32]);
      end
      repeat (2) @(negedge ACLK);
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
    end

    // Slave never accepts AW: AWVALID held exactly 16 cycles, then timeout
    cfg_data = CFG_A; aw_dly = 0; w_dly = 0; b_err = -1; r_bad = -1; aw_never = 1'b1;
    clear_logs();
    run_seq(got);
    chk("tmo_error", error, 1);
    chk("tmo_code", err_code, 3);
    chk("tmo_index", err_index, 0);
    chk("tmo_aw_high", aw_high, 16);
    chk("tmo_aw_cnt", aw_cnt, 0);
    chk("tmo_w_cnt", w_cnt, 1);
    chk("tmo_awvalid_dropped", awvalid, 0);
    aw_never = 1'b0;
    repeat (2) @(negedge ACLK);

    // start pulsed while busy is ignored
    aw_dly = 5;
    clear_logs();
    start = 1'b1; @(negedge ACLK); start = 1'b0;
    repeat (2) @(negedge ACLK);
    start = 1'b1; @(negedge ACLK); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge ACLK);
    end
    chk("busy_start_done", got, 1);
    repeat (5) @(negedge ACLK);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_aw_cnt", aw_cnt, 4);
    chk("busy_start_idle", busy, 0);

    // Reset asserted mid-write drops VALIDs asynchronously
    aw_dly = 5; w_dly = 5;
    clear_logs();
    start = 1'b1; @(negedge ACLK); start = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_valids", {awvalid, wvalid}, 2'b11);
    #2 ARESETN = 1'b0;
    #1;
    chk("async_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_rst_status", {busy, done, error}, 0);
    aw_dly = 0; w_dly = 0;
    clear_logs();
    run_seq(got);
    chk("post_rst_error", error, 0);
    chk("post_rst_aw_cnt", aw_cnt, 4);
    chk("post_rst_w_cnt", w_cnt, 4);
    for (int i = 0; i < 4 && i < w_cnt; i++)
      chk($sformatf("post_rst_wdata%0d", i), w_log[i], CFG_A[32*i +: 32]);
    repeat (2) @(negedge ACLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
